// File: rtl/ad_dac_dma_buffer_pkg.sv
// Shared types and constants for the DAC DMA buffer.
package ad_dac_dma_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PREFILL   = 2'd1,
    RUN       = 2'd2,
    UNDERFLOW = 2'd3
  } state_t;

  localparam int UNF_COUNT_WIDTH = 16;

endpackage

// File: rtl/ad_dac_dma_buffer_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module ad_dac_dma_buffer_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_clr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register is cleared so a fresh session never shows stale data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     rd_data <= '0;
    else if (rd_clr) rd_data <= '0;
    else if (rd_en)  rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ad_dac_dma_buffer.sv
// DMA-to-DAC elastic buffer with prefill and underflow tracking.
// Build option DAC_BUF_HOLD_LAST_EN: hold the last popped word during underflow.
//
// state     | meaning
// IDLE      | all channels disabled; pointers, level, counter cleared
// PREFILL   | accepting beats, no pops until START_LEVEL reached
// RUN       | streaming to the TPL
// UNDERFLOW | read hit empty; refilling to START_LEVEL, dac_dunf high
module ad_dac_dma_buffer
  import ad_dac_dma_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 4,
  parameter int START_LEVEL  = 8
) (
  input  logic                       link_clk,
  input  logic                       link_resetn,
  input  logic                       s_dma_valid,
  output logic                       s_dma_ready,
  input  logic [DATA_WIDTH-1:0]      s_dma_data,
  input  logic [NUM_CHANNELS-1:0]    enable,
  input  logic [NUM_CHANNELS-1:0]    dac_valid,
  output logic [DATA_WIDTH-1:0]      dac_ddata,
  output logic                       dac_dunf,
  output logic [ADDR_WIDTH:0]        level,
  output logic [UNF_COUNT_WIDTH-1:0] unf_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] START_LVL = (ADDR_WIDTH+1)'(START_LEVEL);

  state_t                     state, state_next;
  logic [ADDR_WIDTH-1:0]      wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]        level_q;
  logic [UNF_COUNT_WIDTH-1:0] unf_q;
  logic                       dunf_q;
  logic                       rd_req, wr_en, rd_en, unf_entry;
  logic [DATA_WIDTH-1:0]      rd_data;

  assign rd_req      = |dac_valid;
  assign s_dma_ready = (state != IDLE) && (level_q < FULL_LVL);
  assign wr_en       = s_dma_valid && s_dma_ready;
  // Pops use the registered level, so a same-cycle write into an empty buffer is never popped.
  assign rd_en       = (state == RUN) && rd_req && (level_q != '0);
  assign unf_entry   = (state == RUN) && (state_next == UNDERFLOW);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (|enable) state_next = PREFILL;
      PREFILL:   if (level_q >= START_LVL) state_next = RUN;
      RUN:       if (rd_req && (level_q == '0)) state_next = UNDERFLOW;
      UNDERFLOW: if (level_q >= START_LVL) state_next = RUN;
      default:   state_next = IDLE;
    endcase
    if (!(|enable)) state_next = IDLE;
  end

  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      unf_q   <= '0;
      dunf_q  <= 1'b0;
    end else begin
      state  <= state_next;
      dunf_q <= (state_next == UNDERFLOW);
      if (state_next == IDLE) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
        unf_q   <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        level_q <= level_q + {{ADDR_WIDTH{1'b0}}, wr_en} - {{ADDR_WIDTH{1'b0}}, rd_en};
        if (unf_entry && (unf_q != '1)) unf_q <= unf_q + 1'b1;
      end
    end
  end

  ad_dac_dma_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (link_clk),
    .resetn  (link_resetn),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (s_dma_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_clr  (state == IDLE),
    .rd_data (rd_data)
  );

  always_comb begin
    dac_ddata = '0;
    if (state == RUN) dac_ddata = rd_data;
`ifdef DAC_BUF_HOLD_LAST_EN
    else if (state == UNDERFLOW) dac_ddata = rd_data;
`endif
  end

  assign dac_dunf  = dunf_q;
  assign level     = level_q;
  assign unf_count = unf_q;

endmodule

// File: tb/tb_ad_dac_dma_buffer.sv
// Directed, table-driven bench for ad_dac_dma_buffer (default parameters).
module tb_ad_dac_dma_buffer;

  logic         link_clk;
  logic         link_resetn;
  logic         s_dma_valid;
  logic         s_dma_ready;
  logic [127:0] s_dma_data;
  logic [1:0]   enable;
  logic [1:0]   dac_valid;
  logic [127:0] dac_ddata;
  logic         dac_dunf;
  logic [4:0]   level;
  logic [15:0]  unf_count;

  int checks = 0;
  int failures = 0;

`ifdef DAC_BUF_HOLD_LAST_EN
  localparam logic [127:0] HOLD_A = 128'h0C;
  localparam logic [127:0] HOLD_B = 128'h4F;
`else
  localparam logic [127:0] HOLD_A = 128'h0;
  localparam logic [127:0] HOLD_B = 128'h0;
`endif

  ad_dac_dma_buffer dut (
    .link_clk    (link_clk),
    .link_resetn (link_resetn),
    .s_dma_valid (s_dma_valid),
    .s_dma_ready (s_dma_ready),
    .s_dma_data  (s_dma_data),
    .enable      (enable),
    .dac_valid   (dac_valid),
    .dac_ddata   (dac_ddata),
    .dac_dunf    (dac_dunf),
    .level       (level),
    .unf_count   (unf_count)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  typedef struct {
    logic         valid;
    logic [127:0] data;
    logic [1:0]   en;
    logic [1:0]   dv;
    logic         rdy;
    logic [127:0] dd;
    logic         dunf;
    logic [4:0]   lvl;
    logic [15:0]  unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [127:0] d, logic [1:0] en, logic [1:0] dv,
                              logic rdy, logic [127:0] dd, logic dunf, int lvl, int unf);
    vec_t r;
    r.valid = v; r.data = d; r.en = en; r.dv = dv;
    r.rdy = rdy; r.dd = dd; r.dunf = dunf; r.lvl = 5'(lvl); r.unf = 16'(unf);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic [127:0] dd,
                           input logic dunf, input logic [4:0] lvl, input logic [15:0] unf);
    chk({tag, " ready"}, {127'b0, s_dma_ready}, {127'b0, rdy});
    chk({tag, " ddata"}, dac_ddata, dd);
    chk({tag, " dunf"},  {127'b0, dac_dunf}, {127'b0, dunf});
    chk({tag, " level"}, {123'b0, level}, {123'b0, lvl});
    chk({tag, " unf"},   {112'b0, unf_count}, {112'b0, unf});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic v, input logic [127:0] d, input logic [1:0] en, input logic [1:0] dv);
    @(negedge link_clk);
    s_dma_valid = v;
    s_dma_data  = d;
    enable      = en;
    dac_valid   = dv;
    @(posedge link_clk);
    #1;
  endtask

  initial begin
    link_resetn = 1'b0;
    s_dma_valid = 1'b0;
    s_dma_data  = '0;
    enable      = 2'b00;
    dac_valid   = 2'b00;

    // Prefill, streaming, underflow and refill
    vecs.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, i, 3, 0, 1, 0, 0, i, 0));
    vecs.push_back(mk(0, 0, 3, 0, 1, 0, 0, 8, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 9 + k, 3, 3, 1, 1 + k, 0, 8, 0));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(0, 0, 3, 3, 1, 5 + k, 0, 7 - k, 0));
    vecs.push_back(mk(0, 0, 3, 3, 1, HOLD_A, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3, 3, 1, HOLD_A, 1, 0, 1));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(1, 'h20 + k, 3, 3, 1, HOLD_A, 1, k + 1, 1));
    vecs.push_back(mk(0, 0, 3, 3, 1, 'h0C, 0, 8, 1));
    vecs.push_back(mk(0, 0, 3, 3, 1, 'h20, 0, 7, 1));
    vecs.push_back(mk(1, 'h28, 3, 1, 1, 'h21, 0, 7, 1));

    repeat (3) @(posedge link_clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge link_clk);
    link_resetn = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].valid, vecs[n].data, vecs[n].en, vecs[n].dv);
      check_all($sformatf("vec%0d", n), vecs[n].rdy, vecs[n].dd, vecs[n].dunf, vecs[n].lvl, vecs[n].unf);
    end

    // Disable mid-stream clears level and counter
    step(0, 0, 0, 3);
    check_all("disable", 0, 0, 0, 0, 0);
    step(0, 0, 3, 0);
    check_all("reenable", 1, 0, 0, 0, 0);

    // Fill to full, then push and pop together: the push is rejected
    for (int i = 0; i < 16; i++) begin
      step(1, 'h40 + i, 3, 0);
      chk($sformatf("fill level %0d", i), {123'b0, level}, 128'(i + 1));
    end
    chk("full ready", {127'b0, s_dma_ready}, 128'd0);
    step(1, 'h99, 3, 3);
    check_all("full push+pop", 1, 'h40, 0, 15, 0);
    for (int k = 0; k < 15; k++) begin
      step(0, 0, 3, 3);
      chk($sformatf("drain word %0d", k), dac_ddata, 128'('h41 + k));
    end
    chk("drained level", {123'b0, level}, 128'd0);
    step(0, 0, 3, 3);
    check_all("underflow2", 1, HOLD_B, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 'h60 + i, 3, 3);
    check_all("partial refill", 1, HOLD_B, 1, 3, 1);

    // Asynchronous reset mid-stream discards data, no spurious underflow
    @(negedge link_clk);
    link_resetn = 1'b0;
    #2;
    check_all("async reset", 0, 0, 0, 0, 0);
    step(1, 'h70, 3, 3);
    check_all("held reset", 0, 0, 0, 0, 0);
    link_resetn = 1'b1;
    step(0, 0, 3, 3);
    check_all("post reset", 1, 0, 0, 0, 0);
    step(1, 'h71, 3, 3);
    check_all("post reset write", 1, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
